// File: rtl/ram_arb_pkg.sv
// Shared types and codes for the fetch/data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RMW  = 2'd1,
    RESP = 2'd2
  } arbStateT;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } ownerT;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Unused size code 2'b11 is handled as a word access.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_BYTE: isMisaligned = 1'b0;
      SZ_HALF: isMisaligned = addrLo[0];
      default: isMisaligned = (addrLo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte/half lane handling: merges store data into a RAM word and extracts/extends load data.
module lane_align
  import ram_arb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] oldWord,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        addrLo,
  input  logic              isSigned,
  output logic [DWIDTH-1:0] mergedWord,
  output logic [DWIDTH-1:0] loadData
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  assign byteVal = oldWord[{addrLo, 3'b000} +: 8];
  assign halfVal = oldWord[{addrLo[1], 4'b0000} +: 16];

  always_comb begin
    mergedWord = wdata;
    loadData   = oldWord;
    case (size)
      SZ_BYTE: begin
        mergedWord = oldWord;
        mergedWord[{addrLo, 3'b000} +: 8] = wdata[7:0];
        loadData = {{(DWIDTH-8){isSigned & byteVal[7]}}, byteVal};
      end
      SZ_HALF: begin
        mergedWord = oldWord;
        mergedWord[{addrLo[1], 4'b0000} +: 16] = wdata[15:0];
        loadData = {{(DWIDTH-16){isSigned & halfVal[15]}}, halfVal};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter putting a fetch port and a load/store port onto one word-wide RAM.
//   state | meaning
//   IDLE  | arbitrate; first RAM access driven from the winner's live inputs
//   RMW   | write back merged word of a byte/half store
//   RESP  | pulse ack/err to the owner, then return to IDLE
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_ack,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DWIDTH-1:0] d_rdata,
  output logic [DWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wr_data,
  output logic              ram_rdEn,
  output logic              ram_wrEn,
  output logic              ram_isByte,
  output logic              ram_isHalf,
  output logic              ram_isWord,
  input  logic [DWIDTH-1:0] ram_rd_data
);

  arbStateT          state, nextState;
  ownerT             lastGrant, capOwner;
  logic [AWIDTH-1:0] capAddr;
  logic [DWIDTH-1:0] capWdata;
  logic [1:0]        capSize;
  logic              capSigned, capWe, capErr;
  logic              grantFetch, grantData;
  logic              dMisaligned, dIsWord;
  logic [DWIDTH-1:0] mergedWord, loadData;

  assign dMisaligned = isMisaligned(d_size, d_addr[1:0]);
  assign dIsWord     = (d_size != SZ_BYTE) && (d_size != SZ_HALF);

  assign ram_isByte = 1'b0;
  assign ram_isHalf = 1'b0;
  assign ram_isWord = ram_rdEn | ram_wrEn;

  lane_align #(.DWIDTH(DWIDTH)) uLaneAlign (
    .oldWord   (ram_rd_data),
    .wdata     (capWdata),
    .size      (capSize),
    .addrLo    (capAddr[1:0]),
    .isSigned  (capSigned),
    .mergedWord(mergedWord),
    .loadData  (loadData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= OWN_DATA;
      capOwner  <= OWN_FETCH;
      capAddr   <= '0;
      capWdata  <= '0;
      capSize   <= '0;
      capSigned <= 1'b0;
      capWe     <= 1'b0;
      capErr    <= 1'b0;
    end else begin
      state <= nextState;
      if (grantFetch) begin
        lastGrant <= OWN_FETCH;
        capOwner  <= OWN_FETCH;
        capAddr   <= if_addr;
        capWdata  <= '0;
        capSize   <= SZ_WORD;
        capSigned <= 1'b0;
        capWe     <= 1'b0;
        capErr    <= 1'b0;
      end else if (grantData) begin
        lastGrant <= OWN_DATA;
        capOwner  <= OWN_DATA;
        capAddr   <= d_addr;
        capWdata  <= d_wdata;
        capSize   <= d_size;
        capSigned <= d_signed;
        capWe     <= d_we;
        capErr    <= dMisaligned;
      end
    end
  end

  // rst also gates the grant so nothing reaches the RAM while reset is held.
  always_comb begin
    nextState   = state;
    grantFetch  = 1'b0;
    grantData   = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    ram_rdEn    = 1'b0;
    ram_wrEn    = 1'b0;
    if_ack      = 1'b0;
    if_rdata    = '0;
    d_ack       = 1'b0;
    d_err       = 1'b0;
    d_rdata     = '0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (if_req && (!d_req || lastGrant == OWN_DATA)) begin
            grantFetch = 1'b1;
            ram_rdEn   = 1'b1;
            ram_addr   = DWIDTH'({if_addr[AWIDTH-1:2], 2'b00});
            nextState  = RESP;
          end else if (d_req) begin
            grantData = 1'b1;
            nextState = RESP;
            if (!dMisaligned) begin
              ram_addr = DWIDTH'({d_addr[AWIDTH-1:2], 2'b00});
              if (d_we && dIsWord) begin
                ram_wrEn    = 1'b1;
                ram_wr_data = d_wdata;
              end else begin
                ram_rdEn = 1'b1;
                if (d_we) nextState = RMW;
              end
            end
          end
        end
      end
      RMW: begin
        ram_wrEn    = 1'b1;
        ram_addr    = DWIDTH'({capAddr[AWIDTH-1:2], 2'b00});
        ram_wr_data = mergedWord;
        nextState   = RESP;
      end
      RESP: begin
        nextState = IDLE;
        if (capOwner == OWN_FETCH) begin
          if_ack   = 1'b1;
          if_rdata = ram_rd_data;
        end else if (capErr) begin
          d_err = 1'b1;
        end else begin
          d_ack = 1'b1;
          if (!capWe) d_rdata = loadData;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a registered-read word RAM model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_signed;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr, ram_wr_data;
  logic        ram_rdEn, ram_wrEn, ram_isByte, ram_isHalf, ram_isWord;
  logic [31:0] rdData;

  ram_arbiter #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rdEn(ram_rdEn), .ram_wrEn(ram_wrEn),
    .ram_isByte(ram_isByte), .ram_isHalf(ram_isHalf), .ram_isWord(ram_isWord),
    .ram_rd_data(rdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        isFetch;
    logic        err;
    logic [31:0] data;
    int          lat;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  failures = 0;

  // RAM model
  logic [31:0] mem [0:63];
  logic        preloadEn = 1'b0;
  logic [5:0]  preloadIdx = '0;
  logic [31:0] preloadVal = '0;
  int          rdCount = 0, wrCount = 0, viol = 0;

  always @(posedge clk) begin
    if (preloadEn) mem[preloadIdx] = preloadVal;
    if (ram_rdEn) begin
      rdData <= mem[ram_addr[7:2]];
      rdCount++;
    end
    if (ram_wrEn) begin
      mem[ram_addr[7:2]] = ram_wr_data;
      wrCount++;
    end
  end

  always @(negedge clk) begin
    if (ram_rdEn && ram_wrEn) viol++;
    if (ram_isByte || ram_isHalf) viol++;
    if ((ram_rdEn || ram_wrEn) && ram_addr[1:0] != 2'b00) viol++;
    if (!if_ack && if_rdata !== 32'h0) viol++;
    if (!d_ack && d_rdata !== 32'h0) viol++;
  end

  logic [135:0] allOut;
  assign allOut = {if_ack, if_rdata, d_ack, d_err, d_rdata, ram_addr, ram_wr_data,
                   ram_rdEn, ram_wrEn, ram_isByte, ram_isHalf, ram_isWord};

  function automatic expT mkExp(input logic isFetch, input logic err, input logic [31:0] data, input int lat);
    expT e;
    e.isFetch = isFetch;
    e.err     = err;
    e.data    = data;
    e.lat     = lat;
    return e;
  endfunction

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    preloadIdx = idx;
    preloadVal = val;
    preloadEn  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  task automatic fetchTxn(input logic [31:0] addr, output logic gotAck, output logic [31:0] rdata, output int lat);
    gotAck = 1'b0;
    rdata  = '0;
    lat    = -1;
    if_req  = 1'b1;
    if_addr = addr;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (if_ack) begin
        gotAck = 1'b1;
        rdata  = if_rdata;
        lat    = c;
        break;
      end
    end
    if_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dataTxn(input logic we, input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wd, output logic gotAck, output logic gotErr,
                         output logic [31:0] rdata, output int lat);
    gotAck = 1'b0;
    gotErr = 1'b0;
    rdata  = '0;
    lat    = -1;
    d_req = 1'b1; d_we = we; d_size = sz; d_signed = sgn; d_addr = addr; d_wdata = wd;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (d_ack || d_err) begin
        gotAck = d_ack;
        gotErr = d_err;
        rdata  = d_rdata;
        lat    = c;
        break;
      end
    end
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
    preload(6'd4,  32'hDEADBEEF);
    preload(6'd16, 32'h0BADF00D);
    preload(6'd8,  32'h11223344);
    preload(6'd9,  32'hCAFEF00D);
    preload(6'd10, 32'h00000000);
    preload(6'd12, 32'h80FF0000);
    preload(6'd14, 32'h55667788);
    preload(6'd15, 32'hAABBCCDD);
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h40; d_size = SZ_WORD;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (allOut !== '0) begin
      failures++;
      $display("FAIL reset_outputs_with_req got=%h want=0", allOut);
    end
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (allOut !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got=%h want=0", allOut);
    end
  endtask

  task automatic test_arbitration();
    expT e;
    int  n;
    expQ.push_back(mkExp(1'b1, 1'b0, 32'hDEADBEEF, 1));
    expQ.push_back(mkExp(1'b0, 1'b0, 32'h0BADF00D, 3));
    expQ.push_back(mkExp(1'b1, 1'b0, 32'hDEADBEEF, 5));
    expQ.push_back(mkExp(1'b0, 1'b0, 32'h0BADF00D, 7));
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_signed = 1'b0; d_addr = 32'h40;
    n = 0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (if_ack || d_ack) begin
        e = expQ.pop_front();
        n++;
        checks++;
        if (if_ack !== e.isFetch || d_ack !== !e.isFetch) begin
          failures++;
          $display("FAIL arb_order txn=%0d if_ack=%b d_ack=%b want_fetch=%b", n, if_ack, d_ack, e.isFetch);
        end
        checks++;
        if ((e.isFetch ? if_rdata : d_rdata) !== e.data) begin
          failures++;
          $display("FAIL arb_data txn=%0d got=%h want=%h", n, e.isFetch ? if_rdata : d_rdata, e.data);
        end
        checks++;
        if (c !== e.lat) begin
          failures++;
          $display("FAIL arb_cycle txn=%0d got=%0d want=%0d", n, c, e.lat);
        end
        if (n == 4) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
    end
    if (n < 4) begin
      checks++;
      failures++;
      $display("FAIL arb_timeout got=%0d acks want=4", n);
      expQ.delete();
    end
    if_req = 1'b0; d_req = 1'b0; d_size = 2'b00; d_addr = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_fetch();
    logic        ack;
    logic [31:0] rdata;
    int          lat;
    expT         e;
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(mkExp(1'b1, 1'b0, 32'hDEADBEEF, 1));
      fetchTxn(i == 0 ? 32'h10 : 32'h12, ack, rdata, lat);
      e = expQ.pop_front();
      checks++;
      if (ack !== 1'b1 || lat !== e.lat) begin
        failures++;
        $display("FAIL fetch_latency i=%0d ack=%b got=%0d want=%0d", i, ack, lat, e.lat);
      end
      checks++;
      if (rdata !== e.data) begin
        failures++;
        $display("FAIL fetch_data i=%0d got=%h want=%h", i, rdata, e.data);
      end
    end
  endtask

  task automatic test_store();
    logic        ack, err;
    logic [31:0] rdata, ad, wd;
    logic [1:0]  sz;
    logic [5:0]  idx;
    int          lat, rd0, wr0, expRd;
    expT         e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sz = SZ_WORD; ad = 32'h28; wd = 32'h12345678; idx = 6'd10; expRd = 0;
                 expQ.push_back(mkExp(1'b0, 1'b0, 32'h12345678, 1)); end
        1: begin sz = SZ_BYTE; ad = 32'h22; wd = 32'h000000AA; idx = 6'd8; expRd = 1;
                 expQ.push_back(mkExp(1'b0, 1'b0, 32'h11AA3344, 2)); end
        default: begin sz = SZ_HALF; ad = 32'h26; wd = 32'h0000BEEF; idx = 6'd9; expRd = 1;
                 expQ.push_back(mkExp(1'b0, 1'b0, 32'hBEEFF00D, 2)); end
      endcase
      rd0 = rdCount;
      wr0 = wrCount;
      dataTxn(1'b1, sz, 1'b0, ad, wd, ack, err, rdata, lat);
      e = expQ.pop_front();
      checks++;
      if (ack !== 1'b1 || err !== 1'b0 || lat !== e.lat) begin
        failures++;
        $display("FAIL store_ack i=%0d ack=%b err=%b lat=%0d want_lat=%0d", i, ack, err, lat, e.lat);
      end
      checks++;
      if (rdCount - rd0 !== expRd || wrCount - wr0 !== 1) begin
        failures++;
        $display("FAIL store_ram_ops i=%0d rd=%0d wr=%0d want rd=%0d wr=1", i, rdCount - rd0, wrCount - wr0, expRd);
      end
      checks++;
      if (mem[idx] !== e.data) begin
        failures++;
        $display("FAIL store_word i=%0d got=%h want=%h", i, mem[idx], e.data);
      end
    end
  endtask

  task automatic test_load();
    logic        ack, err, sgn;
    logic [31:0] rdata, ad;
    logic [1:0]  sz;
    int          lat, rd0;
    expT         e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin sz = SZ_BYTE; sgn = 1'b1; ad = 32'h33; expQ.push_back(mkExp(1'b0, 1'b0, 32'hFFFFFF80, 1)); end
        1: begin sz = SZ_BYTE; sgn = 1'b0; ad = 32'h33; expQ.push_back(mkExp(1'b0, 1'b0, 32'h00000080, 1)); end
        2: begin sz = SZ_HALF; sgn = 1'b1; ad = 32'h32; expQ.push_back(mkExp(1'b0, 1'b0, 32'hFFFF80FF, 1)); end
        3: begin sz = SZ_HALF; sgn = 1'b1; ad = 32'h30; expQ.push_back(mkExp(1'b0, 1'b0, 32'h00000000, 1)); end
        4: begin sz = SZ_BYTE; sgn = 1'b1; ad = 32'h32; expQ.push_back(mkExp(1'b0, 1'b0, 32'hFFFFFFFF, 1)); end
        default: begin sz = SZ_WORD; sgn = 1'b1; ad = 32'h30; expQ.push_back(mkExp(1'b0, 1'b0, 32'h80FF0000, 1)); end
      endcase
      rd0 = rdCount;
      dataTxn(1'b0, sz, sgn, ad, 32'h0, ack, err, rdata, lat);
      e = expQ.pop_front();
      checks++;
      if (ack !== 1'b1 || lat !== e.lat || rdCount - rd0 !== 1) begin
        failures++;
        $display("FAIL load_ack i=%0d ack=%b lat=%0d rd=%0d want ack=1 lat=%0d rd=1", i, ack, lat, rdCount - rd0, e.lat);
      end
      checks++;
      if (rdata !== e.data) begin
        failures++;
        $display("FAIL load_data i=%0d got=%h want=%h", i, rdata, e.data);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        ack, err, we;
    logic [31:0] rdata, ad;
    logic [1:0]  sz;
    int          lat, rd0, wr0;
    expT         e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin we = 1'b1; sz = SZ_HALF; ad = 32'h21; end
      else        begin we = 1'b0; sz = SZ_WORD; ad = 32'h22; end
      expQ.push_back(mkExp(1'b0, 1'b1, 32'h11AA3344, 1));
      rd0 = rdCount;
      wr0 = wrCount;
      dataTxn(we, sz, 1'b0, ad, 32'h0000FFFF, ack, err, rdata, lat);
      e = expQ.pop_front();
      checks++;
      if (err !== e.err || ack !== 1'b0 || lat !== e.lat || rdata !== 32'h0) begin
        failures++;
        $display("FAIL misaligned_err i=%0d err=%b ack=%b lat=%0d rdata=%h want err=1 ack=0 lat=1 rdata=0", i, err, ack, lat, rdata);
      end
      checks++;
      if (rdCount - rd0 !== 0 || wrCount - wr0 !== 0) begin
        failures++;
        $display("FAIL misaligned_ram_ops i=%0d rd=%0d wr=%0d want 0", i, rdCount - rd0, wrCount - wr0);
      end
      checks++;
      if (mem[8] !== e.data) begin
        failures++;
        $display("FAIL misaligned_mem i=%0d got=%h want=%h", i, mem[8], e.data);
      end
    end
  endtask

  task automatic test_reset_rmw();
    int  wr0;
    expT e;
    expQ.push_back(mkExp(1'b0, 1'b0, 32'h55667788, 0));
    wr0 = wrCount;
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_BYTE; d_signed = 1'b0; d_addr = 32'h39; d_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ram_wrEn !== 1'b1) begin
      failures++;
      $display("FAIL rmw_reached got_wrEn=%b want=1", ram_wrEn);
    end
    rst = 1'b1;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0;
    #1;
    checks++;
    if (allOut !== '0) begin
      failures++;
      $display("FAIL rmw_reset_outputs got=%h want=0", allOut);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    e = expQ.pop_front();
    checks++;
    if (wrCount - wr0 !== 0 || mem[14] !== e.data || d_ack !== 1'b0) begin
      failures++;
      $display("FAIL rmw_reset_abandon wr=%0d mem=%h d_ack=%b want wr=0 mem=%h d_ack=0", wrCount - wr0, mem[14], d_ack, e.data);
    end
  endtask

  task automatic test_early_drop();
    expT e;
    expQ.push_back(mkExp(1'b0, 1'b0, 32'hAABBCC11, 2));
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_BYTE; d_signed = 1'b0; d_addr = 32'h3C; d_wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    e = expQ.pop_front();
    checks++;
    if (d_ack !== 1'b1 || mem[15] !== e.data) begin
      failures++;
      $display("FAIL early_drop d_ack=%b mem=%h want d_ack=1 mem=%h", d_ack, mem[15], e.data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL invariants got=%0d violations want=0", viol);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arbitration();
    test_fetch();
    test_store();
    test_load();
    test_misaligned();
    test_reset_rmw();
    test_early_drop();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

endmodule
